// File: rtl/px_adc_capture_pkg.sv
// Shared types, frame geometry and word packing for the pixel ADC capture path.
package senseye_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2,
        ST_WRITE = 2'd3
    } adc_state_t;

    localparam int unsigned ADC_BITS   = 12;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned LEAD_ZEROS = 4;

    // Capture FIFO word: px1 in the upper half-word, px0 in the lower, each zero-padded.
    function automatic logic [31:0] pack_word(input logic [ADC_BITS-1:0] px0,
                                              input logic [ADC_BITS-1:0] px1);
        return {4'b0, px1, 4'b0, px0};
    endfunction

    // The ADC drives leading zeros ahead of its data; any 1 there means a corrupt frame.
    function automatic logic lead_nonzero(input logic [LEAD_ZEROS-1:0] lead);
        return |lead;
    endfunction

endpackage

// File: rtl/px_adc_capture_sclk_gen.sv
// SCLK generator: DIV-cycle prescaler plus a 33-step half-period counter.
// hp_q counts down from 32, so half-period index h = 32 - hp_q and shares its parity.
module adc_sclk_gen #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    output logic sclk_o,
    output logic sample_stb_o,
    output logic frame_done_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LOAD = PW'(DIV - 1);
    localparam logic [5:0]    HP_LOAD  = 6'd32;

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    hp_q, hp_d;
    logic          sclk_q, sclk_d;
    logic          pre_tc;

    assign pre_tc       = (pre_q == '0);
    assign frame_done_o = run_i && pre_tc && (hp_q == '0);
    // First cycle of every even h >= 2 (hp even and at most 30).
    assign sample_stb_o = run_i && (pre_q == PRE_LOAD) && !hp_q[0] && (hp_q <= 6'd30);
    assign sclk_o       = sclk_q;

    // Next counter values; SCLK is registered from the half-period index of the next cycle.
    always_comb begin
        pre_d  = PRE_LOAD;
        hp_d   = HP_LOAD;
        sclk_d = 1'b1;
        if (run_i && !frame_done_o) begin
            if (pre_tc) begin
                pre_d = PRE_LOAD;
                hp_d  = hp_q - 6'd1;
            end else begin
                pre_d = pre_q - PW'(1);
                hp_d  = hp_q;
            end
            sclk_d = ~hp_d[0];
        end
    end

    // Counters stay preloaded while idle so the first CONV cycle is h=0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pre_q  <= PRE_LOAD;
            hp_q   <= HP_LOAD;
            sclk_q <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            hp_q   <= hp_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/px_adc_capture.sv
// Dual-channel serial ADC capture: one 16-bit frame per start_cap, packed into one FIFO word.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | CS high, waiting for start_cap
// ST_CONV  | CS low, 33 SCLK half-periods, 16 samples per channel
// ST_QUIET | CS high for QUIET cycles before the FIFO write
// ST_WRITE | one cycle: conv_complete, wr_en or overrun
module px_adc_capture
    import senseye_adc_pkg::*;
#(
    parameter int DIV   = 2,
    parameter int QUIET = 4
) (
    input  logic        CLK50,
    input  logic        MSS_RESET_N,
    input  logic        start_cap,
    input  logic        px0_adc_din,
    input  logic        px1_adc_din,
    input  logic        fifo_full,
    output logic        CS,
    output logic        SCLK,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        conv_complete,
    output logic        overrun,
    output logic        adc_err
);

    localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam logic [QW-1:0] Q_LOAD = QW'(QUIET - 1);

    adc_state_t            state_q;
    logic                  cs_q;
    logic                  wr_en_q;
    logic [31:0]           wr_data_q;
    logic                  busy_q;
    logic                  cc_q;
    logic                  overrun_q;
    logic                  adc_err_q;
    logic [FRAME_BITS-1:0] sh0_q, sh1_q;
    logic [QW-1:0]         qcnt_q;

    logic run;
    logic sample_stb;
    logic frame_done;

    assign run = (state_q == ST_CONV);

    adc_sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk_i        (CLK50),
        .rst_n_i      (MSS_RESET_N),
        .run_i        (run),
        .sclk_o       (SCLK),
        .sample_stb_o (sample_stb),
        .frame_done_o (frame_done)
    );

    assign CS            = cs_q;
    assign wr_en         = wr_en_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign conv_complete = cc_q;
    assign overrun       = overrun_q;
    assign adc_err       = adc_err_q;

    // Frame sequencer with registered outputs. The write/drop decision is registered on
    // the edge that enters ST_WRITE, so wr_en and wr_data are valid together in that cycle.
    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            state_q   <= ST_IDLE;
            cs_q      <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            cc_q      <= 1'b0;
            overrun_q <= 1'b0;
            adc_err_q <= 1'b0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            qcnt_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            cc_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_cap) begin
                        state_q   <= ST_CONV;
                        cs_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                        adc_err_q <= 1'b0;
                        sh0_q     <= '0;
                        sh1_q     <= '0;
                    end
                end
                ST_CONV: begin
                    if (sample_stb) begin
                        sh0_q <= {sh0_q[FRAME_BITS-2:0], px0_adc_din};
                        sh1_q <= {sh1_q[FRAME_BITS-2:0], px1_adc_din};
                    end
                    if (frame_done) begin
                        state_q <= ST_QUIET;
                        cs_q    <= 1'b1;
                        qcnt_q  <= Q_LOAD;
                    end
                end
                ST_QUIET: begin
                    if (qcnt_q == '0) begin
                        state_q   <= ST_WRITE;
                        cc_q      <= 1'b1;
                        adc_err_q <= adc_err_q
                                   | lead_nonzero(sh0_q[FRAME_BITS-1:ADC_BITS])
                                   | lead_nonzero(sh1_q[FRAME_BITS-1:ADC_BITS]);
                        if (!fifo_full) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= pack_word(sh0_q[ADC_BITS-1:0], sh1_q[ADC_BITS-1:0]);
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        qcnt_q <= qcnt_q - QW'(1);
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_px_adc_capture.sv
// Bench for px_adc_capture: default-timing instance (a) and a DIV=1/QUIET=1 instance (b),
// each fed by a serial ADC model, checked against frame-level expectations.
module tb_px_adc_capture;

    localparam int DIV_A   = 2;
    localparam int QUIET_A = 4;
    localparam int DIV_B   = 1;
    localparam int QUIET_B = 1;

    logic        CLK50       = 1'b0;
    logic        MSS_RESET_N = 1'b0;

    logic        start_a = 1'b0, din0_a = 1'b0, din1_a = 1'b0, full_a = 1'b0;
    logic        cs_a, sclk_a, wr_en_a, busy_a, cc_a, ovr_a, err_a;
    logic [31:0] wr_data_a;

    logic        start_b = 1'b0, din0_b = 1'b0, din1_b = 1'b0, full_b = 1'b0;
    logic        cs_b, sclk_b, wr_en_b, busy_b, cc_b, ovr_b, err_b;
    logic [31:0] wr_data_b;

    int checks = 0;
    int errors = 0;

    logic [15:0] f0_a = '0, f1_a = '0, f0_b = '0, f1_b = '0;
    int          bit_a = 15, bit_b = 15;
    logic [31:0] last_a = '0, last_b = '0;

    always #5 CLK50 = ~CLK50;

    px_adc_capture #(.DIV(DIV_A), .QUIET(QUIET_A)) dut_a (
        .CLK50 (CLK50), .MSS_RESET_N (MSS_RESET_N), .start_cap (start_a),
        .px0_adc_din (din0_a), .px1_adc_din (din1_a), .fifo_full (full_a),
        .CS (cs_a), .SCLK (sclk_a), .wr_en (wr_en_a), .wr_data (wr_data_a),
        .busy (busy_a), .conv_complete (cc_a), .overrun (ovr_a), .adc_err (err_a)
    );

    px_adc_capture #(.DIV(DIV_B), .QUIET(QUIET_B)) dut_b (
        .CLK50 (CLK50), .MSS_RESET_N (MSS_RESET_N), .start_cap (start_b),
        .px0_adc_din (din0_b), .px1_adc_din (din1_b), .fifo_full (full_b),
        .CS (cs_b), .SCLK (sclk_b), .wr_en (wr_en_b), .wr_data (wr_data_b),
        .busy (busy_b), .conv_complete (cc_b), .overrun (ovr_b), .adc_err (err_b)
    );

    // ADC models: next bit (MSB first) presented on each SCLK fall while CS is low.
    always @(negedge sclk_a or posedge cs_a) begin
        if (cs_a) bit_a = 15;
        else begin
            if (bit_a >= 0) begin din0_a = f0_a[bit_a]; din1_a = f1_a[bit_a]; end
            bit_a = bit_a - 1;
        end
    end

    always @(negedge sclk_b or posedge cs_b) begin
        if (cs_b) bit_b = 15;
        else begin
            if (bit_b >= 0) begin din0_b = f0_b[bit_b]; din1_b = f1_b[bit_b]; end
            bit_b = bit_b - 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a frame's word keeps the low 12 bits of each channel, px1 above px0.
    function automatic logic [31:0] model_word(input logic [15:0] f0, input logic [15:0] f1);
        return ((32'(f1) % 32'd4096) * 32'd65536) + (32'(f0) % 32'd4096);
    endfunction

    function automatic logic model_err(input logic [15:0] f0, input logic [15:0] f1);
        return (f0 > 16'h0FFF) || (f1 > 16'h0FFF);
    endfunction

    function automatic logic [15:0] rand_frame();
        logic [15:0] f;
        f = 16'($urandom_range(0, 4095));
        if ($urandom_range(0, 3) == 0) f = f + 16'($urandom_range(1, 15) * 4096);
        return f;
    endfunction

    // Entered on a negedge. Starts a frame, observes cycles k+1..k+lat+1, then checks.
    task automatic frame(input bit sel, input logic [15:0] f0, input logic [15:0] f1,
                         input logic full, input int poke0, input int poke1, input string tag);
        int div, lat, cs_low, first_cs, first_fall, rises, first_rise, last_rise;
        int wr_cnt, wr_at, cc_cnt, cc_at, busy_bad;
        logic prev_sclk, o_cs, o_sclk, o_wr, o_cc, o_busy, s;
        logic [31:0] o_data, data_at_wr, exp_word, exp_last;
        div = sel ? DIV_B : DIV_A;
        lat = 1 + 33 * div + (sel ? QUIET_B : QUIET_A);
        cs_low = 0; first_cs = -1; first_fall = -1; rises = 0; first_rise = -1; last_rise = -1;
        wr_cnt = 0; wr_at = -1; cc_cnt = 0; cc_at = -1; busy_bad = 0;
        prev_sclk = 1'b1; data_at_wr = '0;
        if (sel) begin f0_b = f0; f1_b = f1; full_b = full; start_b = 1'b1; end
        else     begin f0_a = f0; f1_a = f1; full_a = full; start_a = 1'b1; end
        @(posedge CLK50);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge CLK50);
            s = (n == poke0) || (n == poke1);
            if (sel) start_b = s; else start_a = s;
            o_cs   = sel ? cs_b      : cs_a;
            o_sclk = sel ? sclk_b    : sclk_a;
            o_wr   = sel ? wr_en_b   : wr_en_a;
            o_cc   = sel ? cc_b      : cc_a;
            o_busy = sel ? busy_b    : busy_a;
            o_data = sel ? wr_data_b : wr_data_a;
            if (n == 1) begin
                chk({tag, " overrun cleared"}, sel ? ovr_b : ovr_a, 0);
                chk({tag, " adc_err cleared"}, sel ? err_b : err_a, 0);
            end
            if (!o_cs) begin cs_low++; if (first_cs < 0) first_cs = n; end
            if (prev_sclk && !o_sclk && first_fall < 0) first_fall = n;
            if (!prev_sclk && o_sclk) begin
                rises++; last_rise = n;
                if (first_rise < 0) first_rise = n;
            end
            prev_sclk = o_sclk;
            if (o_wr) begin wr_cnt++; wr_at = n; data_at_wr = o_data; end
            if (o_cc) begin cc_cnt++; cc_at = n; end
            if (o_busy !== (n <= lat)) busy_bad++;
        end
        exp_word = model_word(f0, f1);
        exp_last = sel ? last_b : last_a;
        if (!full) exp_last = exp_word;
        chk({tag, " cs low cycles"}, cs_low, 33 * div);
        chk({tag, " cs first low"}, first_cs, 1);
        chk({tag, " sclk first fall"}, first_fall, 1 + div);
        chk({tag, " sclk rises"}, rises, 16);
        chk({tag, " sclk first rise"}, first_rise, 1 + 2 * div);
        chk({tag, " sclk last rise"}, last_rise, 1 + 32 * div);
        chk({tag, " conv_complete count"}, cc_cnt, 1);
        chk({tag, " conv_complete cycle"}, cc_at, lat);
        chk({tag, " wr_en count"}, wr_cnt, full ? 0 : 1);
        if (!full) begin
            chk({tag, " wr_en cycle"}, wr_at, lat);
            chk({tag, " wr_data at write"}, data_at_wr, exp_word);
        end
        chk({tag, " busy window"}, busy_bad, 0);
        chk({tag, " wr_data held"}, sel ? wr_data_b : wr_data_a, exp_last);
        chk({tag, " overrun"}, sel ? ovr_b : ovr_a, full);
        chk({tag, " adc_err"}, sel ? err_b : err_a, model_err(f0, f1));
        if (sel) last_b = exp_last; else last_a = exp_last;
    endtask

    initial begin
        int wr_seen, cc_seen, cs_seen;
        logic [15:0] r0, r1;

        // Reset values
        repeat (2) @(negedge CLK50);
        chk("reset CS", cs_a, 1);
        chk("reset SCLK", sclk_a, 1);
        chk("reset wr_en", wr_en_a, 0);
        chk("reset wr_data", wr_data_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset conv_complete", cc_a, 0);
        chk("reset overrun", ovr_a, 0);
        chk("reset adc_err", err_a, 0);
        chk("reset b CS", cs_b, 1);
        chk("reset b SCLK", sclk_b, 1);
        chk("reset b busy", busy_b, 0);
        MSS_RESET_N = 1'b1;
        repeat (3) @(negedge CLK50);

        // Directed frame
        frame(1'b0, 16'h0ABC, 16'h0123, 1'b0, -1, -1, "basic");
        chk("basic packed word", wr_data_a, 32'h01230ABC);
        repeat (3) @(negedge CLK50);

        // FIFO full: frame dropped, overrun sticky until next accepted start
        frame(1'b0, rand_frame(), rand_frame(), 1'b1, -1, -1, "full");
        repeat (20) @(negedge CLK50);
        chk("overrun sticky", ovr_a, 1);
        chk("wr_data held after drop", wr_data_a, last_a);

        // Leading-one error on px1
        r0 = 16'($urandom_range(0, 4095));
        frame(1'b0, r0, 16'h8FFF, 1'b0, -1, -1, "lead err");
        chk("lead err px1 lane", wr_data_a[27:16], 12'hFFF);
        chk("lead err px0 lane", wr_data_a[11:0], r0[11:0]);
        repeat (2) @(negedge CLK50);

        // Starts during CONV and WRITE ignored; start at k+72 accepted
        frame(1'b0, rand_frame(), rand_frame(), 1'b0, 10, 71, "ignored starts");
        frame(1'b0, rand_frame(), rand_frame(), 1'b0, -1, -1, "back to back");
        repeat (2) @(negedge CLK50);

        // Reset mid-frame
        f0_a = 16'h0F0F; f1_a = 16'h00F0; full_a = 1'b0; start_a = 1'b1;
        @(posedge CLK50);
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK50);
            start_a = 1'b0;
        end
        MSS_RESET_N = 1'b0;
        #1;
        chk("mid reset CS", cs_a, 1);
        chk("mid reset SCLK", sclk_a, 1);
        chk("mid reset busy", busy_a, 0);
        last_a = '0;
        last_b = '0;
        repeat (2) @(negedge CLK50);
        MSS_RESET_N = 1'b1;
        wr_seen = 0; cc_seen = 0; cs_seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge CLK50);
            if (wr_en_a) wr_seen++;
            if (cc_a) cc_seen++;
            if (!cs_a) cs_seen++;
        end
        chk("post reset no wr_en", wr_seen, 0);
        chk("post reset no conv_complete", cc_seen, 0);
        chk("post reset CS idle", cs_seen, 0);
        chk("post reset wr_data", wr_data_a, 0);
        frame(1'b0, rand_frame(), rand_frame(), 1'b0, -1, -1, "after reset");

        // Randomized frames on the default instance
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge CLK50);
            frame(1'b0, rand_frame(), rand_frame(), 1'($urandom_range(0, 3) == 0), -1, -1,
                  $sformatf("rand a%0d", i));
        end

        // Fast instance
        frame(1'b1, 16'h0555, 16'h0AAA, 1'b0, -1, -1, "fast");
        chk("fast packed word", wr_data_b, 32'h0AAA0555);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK50);
            frame(1'b1, rand_frame(), rand_frame(), 1'($urandom_range(0, 3) == 0), -1, -1,
                  $sformatf("rand b%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/px_adc_capture.md
# px_adc_capture

Dual-channel serial ADC front end for the Stonyman pixel readout path. On each `start_cap` pulse from the pixel sequencer it runs one 16-bit conversion frame on the two ADCs that share `CS`/`SCLK` (`px0_adc_din`, `px1_adc_din`). It then writes one packed 32-bit word into the downstream capture FIFO read by the APB slave. It sits between the sensor control sequencer (upstream) and the capture FIFO (downstream).

## Interface
- `DIV`, default 2: `CLK50` cycles per `SCLK` half-period (≥1). The default gives a 12.5 MHz `SCLK`.
- `QUIET`, default 4: `CLK50` cycles `CS` is held high after a frame, before the write (≥1).
- `CLK50` input 1: sole clock; all logic on its rising edge.
- `MSS_RESET_N` input 1: reset, asynchronous assert, active-low.
- `start_cap` input 1: single-cycle conversion request from the sequencer.
- `px0_adc_din` input 1: ADC0 serial data, MSB first.
- `px1_adc_din` input 1: ADC1 serial data, MSB first.
- `fifo_full` input 1: capture FIFO full.
- `CS` output 1: ADC chip select, active-low.
- `SCLK` output 1: ADC serial clock, idles high.
- `wr_en` output 1: FIFO write strobe, one cycle.
- `wr_data` output 32: `{4'b0, px1[11:0], 4'b0, px0[11:0]}`.
- `busy` output 1: frame in progress.
- `conv_complete` output 1: one-cycle pulse at the end of each frame, written or dropped.
- `overrun` output 1: sticky; a frame was dropped because the FIFO was full.
- `adc_err` output 1: sticky; a leading-zero bit read as 1 on either channel.

## Operation
- States: IDLE, CONV, QUIET, WRITE.
- IDLE:
  - `CS`=1, `SCLK`=1.
  - `start_cap`=1 → CONV. Clear `overrun` and `adc_err`, zero both shift registers.
- CONV:
  - `CS`=0.
  - Half-period index h runs 0..32, each h lasting `DIV` cycles.
  - h=0: `SCLK` high (CS setup).
  - Odd h: `SCLK` low. Even h≥2: `SCLK` high.
  - On the first cycle of each even h≥2, sample both `din` lines and shift them in MSB first. This gives 16 samples.
  - After h=32 → QUIET.
- Frame bits 15..12 must be 0; any 1 sets `adc_err`. Bits 11..0 are data.
- QUIET: `CS`=1, `SCLK`=1 for `QUIET` cycles, then → WRITE.
- WRITE, one cycle:
  - Pulse `conv_complete`.
  - If `fifo_full`=0, pulse `wr_en` with `wr_data` valid in the same cycle.
  - Else drop the word and set `overrun`.
  - → IDLE.
- `start_cap` outside IDLE is ignored; it is neither queued nor counted.
- `wr_data` holds the last packed value between writes.
- Reset mid-frame: return to IDLE immediately with the reset values below. The partial frame is discarded and no write occurs.

## Timing
- Reset values:
  - `CS`=1, `SCLK`=1.
  - `wr_en`=0, `wr_data`=0.
  - `busy`=0, `conv_complete`=0.
  - `overrun`=0, `adc_err`=0.
  - State IDLE.
- All outputs are registered.
- `start_cap` sampled high at edge k. With defaults:
  - `CS` is low k+1..k+66 (33·`DIV` cycles).
  - `SCLK` first falls at k+3.
  - The 16 rising `SCLK` edges are at k+5, k+9, …, k+65.
  - QUIET is k+67..k+70.
  - `wr_en`/`conv_complete` are at k+71.
- General latency from start to write is 1 + 33·`DIV` + `QUIET` cycles.
- `busy` is high k+1..k+71. IDLE is re-entered at k+72, so `start_cap` at k+72 is accepted. The minimum frame spacing is 72 cycles.
- `fifo_full` is sampled only in the WRITE cycle.
- `din` is sampled without a synchronizer. The ADC data is timed relative to `SCLK`, which is generated by this block.

## Structure
- Package `senseye_adc_pkg`:
  - State enum `adc_state_t`.
  - `ADC_BITS`=12, `FRAME_BITS`=16, `LEAD_ZEROS`=4.
  - Packing function for `wr_data`.
- Optional sub-module `adc_sclk_gen`: `DIV` prescaler plus half-period counter. It outputs `SCLK`, `sample_stb` and `frame_done`.
- FSM, shift registers and sticky flags stay in the top module.

## Test plan
- ADC model with `DIV`=2, `QUIET`=4, `fifo_full`=0. px0 frame 0x0ABC, px1 frame 0x0123, `start_cap` at k → single `wr_en` at k+71, `wr_data`=0x01230ABC, `overrun`=0, `adc_err`=0. Bench also checks 16 `SCLK` rises and a 66-cycle `CS` low window.
- `fifo_full`=1 during WRITE → `conv_complete` at k+71, no `wr_en`, `overrun`=1. It stays 1 until the next accepted `start_cap` clears it.
- px1 frame 0x8FFF → `adc_err`=1, `wr_data[27:16]`=0xFFF; px0 lane unaffected.
- `start_cap` pulses at k+10 and k+71 → both ignored, exactly one write. A pulse at k+72 starts a new frame, with `CS` falling at k+73.
- `MSS_RESET_N` asserted at k+30 → `CS`=1, `SCLK`=1, `busy`=0 immediately. No `wr_en` follows; a new `start_cap` after release works normally.
- `DIV`=1, `QUIET`=1 → `wr_en` at k+35, and data is correct for the pattern 0x0555/0x0AAA.
